// File: rtl/per2axi_mo.sv
// per2axi_mo: multi-outstanding bridge from the 32-bit peripheral interconnect to AXI4.
// Each granted peripheral request becomes one single-beat AXI read or write. Up to
// NB_OUTSTANDING reads and NB_OUTSTANDING writes may be in flight. The AXI ID is
// constant, so responses come back in order and are matched by simple FIFOs.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   per_req_i / per_gnt_o         peripheral request / combinational grant
//   per_add_i, per_wen_i          byte address, 1 = read / 0 = write
//   per_wdata_i, per_be_i         write data and byte enables
//   per_id_i                      request ID, echoed on the response
//   per_r_valid_o/opc_o/id_o/rdata_o  one-cycle response strobe and payload
//   axi_aw_* / axi_ar_*           address channels (single beat, 32-bit size, INCR)
//   axi_w_*                       write data channel, word replicated on every lane
//   axi_r_* / axi_b_*             read data / write response channels
//   busy_o                        any request pending or in flight
module per2axi_mo #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 6,
  parameter int NB_OUTSTANDING = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        per_req_i,
  output logic                        per_gnt_o,
  input  logic [PER_ADDR_WIDTH-1:0]   per_add_i,
  input  logic                        per_wen_i,
  input  logic [31:0]                 per_wdata_i,
  input  logic [3:0]                  per_be_i,
  input  logic [PER_ID_WIDTH-1:0]     per_id_i,
  output logic                        per_r_valid_o,
  output logic                        per_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]     per_r_id_o,
  output logic [31:0]                 per_r_rdata_o,
  output logic                        axi_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
  output logic [2:0]                  axi_aw_prot_o,
  output logic [3:0]                  axi_aw_region_o,
  output logic [7:0]                  axi_aw_len_o,
  output logic [2:0]                  axi_aw_size_o,
  output logic [1:0]                  axi_aw_burst_o,
  output logic                        axi_aw_lock_o,
  output logic [3:0]                  axi_aw_cache_o,
  output logic [3:0]                  axi_aw_qos_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_user_o,
  input  logic                        axi_aw_ready_i,
  output logic                        axi_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
  output logic [2:0]                  axi_ar_prot_o,
  output logic [3:0]                  axi_ar_region_o,
  output logic [7:0]                  axi_ar_len_o,
  output logic [2:0]                  axi_ar_size_o,
  output logic [1:0]                  axi_ar_burst_o,
  output logic                        axi_ar_lock_o,
  output logic [3:0]                  axi_ar_cache_o,
  output logic [3:0]                  axi_ar_qos_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_user_o,
  input  logic                        axi_ar_ready_i,
  output logic                        axi_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_user_o,
  output logic                        axi_w_last_o,
  input  logic                        axi_w_ready_i,
  input  logic                        axi_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
  input  logic [1:0]                  axi_r_resp_i,
  output logic                        axi_r_ready_o,
  input  logic                        axi_b_valid_i,
  input  logic [1:0]                  axi_b_resp_i,
  output logic                        axi_b_ready_o,
  output logic                        busy_o
);

  localparam int NB_LANES = AXI_DATA_WIDTH / 32;
  localparam int LANE_W   = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int PTR_W    = (NB_OUTSTANDING > 1) ? $clog2(NB_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(NB_OUTSTANDING + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NB_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [LANE_W-1:0] lane;
  generate
    if (NB_LANES > 1) begin : g_lane
      assign lane = per_add_i[$clog2(STRB_W)-1:2];
    end else begin : g_nolane
      assign lane = '0;
    end
  endgenerate

  logic                      ar_valid_p0, aw_valid_p0, w_valid_p0;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_p0, aw_addr_p0;
  logic [AXI_DATA_WIDTH-1:0] w_data_p0;
  logic [STRB_W-1:0]         w_strb_p0;

  logic [PER_ID_WIDTH-1:0] rd_id_mem   [NB_OUTSTANDING];
  logic [LANE_W-1:0]       rd_lane_mem [NB_OUTSTANDING];
  logic [PER_ID_WIDTH-1:0] wr_id_mem   [NB_OUTSTANDING];
  logic [PTR_W-1:0]        rd_wptr, rd_rptr, wr_wptr, wr_rptr;
  logic [CNT_W-1:0]        rd_cnt, wr_cnt;
  logic                    rd_full, wr_full, rd_gnt, wr_gnt, r_hs, b_hs;

  logic                    rsp_valid_p1, rsp_opc_p1;
  logic [PER_ID_WIDTH-1:0] rsp_id_p1;
  logic [31:0]             rsp_rdata_p1;

  // Only the error bit of each response is meaningful to the peripheral side.
  logic resp_lsb_unused;
  assign resp_lsb_unused = axi_r_resp_i[0] ^ axi_b_resp_i[0];

  assign rd_full = (rd_cnt == CNT_W'(NB_OUTSTANDING));
  assign wr_full = (wr_cnt == CNT_W'(NB_OUTSTANDING));

  assign rd_gnt    = per_req_i & per_wen_i & ~ar_valid_p0 & ~rd_full;
  assign wr_gnt    = per_req_i & ~per_wen_i & ~aw_valid_p0 & ~w_valid_p0 & ~wr_full;
  assign per_gnt_o = rd_gnt | wr_gnt;

  // R always wins a simultaneous R/B arrival; B simply waits a cycle.
  assign axi_r_ready_o = (rd_cnt != '0);
  assign axi_b_ready_o = (wr_cnt != '0) & ~axi_r_valid_i;
  assign r_hs = axi_r_valid_i & axi_r_ready_o;
  assign b_hs = axi_b_valid_i & axi_b_ready_o;

  // ---- stage p0: AXI request registers, each held until its own ready ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_valid_p0 <= 1'b0;
      aw_valid_p0 <= 1'b0;
      w_valid_p0  <= 1'b0;
      ar_addr_p0  <= '0;
      aw_addr_p0  <= '0;
      w_data_p0   <= '0;
      w_strb_p0   <= '0;
    end else begin
      if (rd_gnt) begin
        ar_valid_p0 <= 1'b1;
        ar_addr_p0  <= AXI_ADDR_WIDTH'(per_add_i);
      end else if (axi_ar_ready_i) begin
        ar_valid_p0 <= 1'b0;
      end
      if (wr_gnt) begin
        aw_valid_p0 <= 1'b1;
        w_valid_p0  <= 1'b1;
        aw_addr_p0  <= AXI_ADDR_WIDTH'(per_add_i);
        w_data_p0   <= {NB_LANES{per_wdata_i}};
        w_strb_p0   <= STRB_W'(per_be_i) << (4 * lane);
      end else begin
        if (axi_aw_ready_i) aw_valid_p0 <= 1'b0;
        if (axi_w_ready_i)  w_valid_p0  <= 1'b0;
      end
    end
  end

  // Tracking FIFO control: push on grant, pop on response handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_wptr <= '0;
      rd_rptr <= '0;
      rd_cnt  <= '0;
      wr_wptr <= '0;
      wr_rptr <= '0;
      wr_cnt  <= '0;
    end else begin
      if (rd_gnt) rd_wptr <= ptr_inc(rd_wptr);
      if (r_hs)   rd_rptr <= ptr_inc(rd_rptr);
      if (rd_gnt && !r_hs)      rd_cnt <= rd_cnt + CNT_W'(1);
      else if (!rd_gnt && r_hs) rd_cnt <= rd_cnt - CNT_W'(1);
      if (wr_gnt) wr_wptr <= ptr_inc(wr_wptr);
      if (b_hs)   wr_rptr <= ptr_inc(wr_rptr);
      if (wr_gnt && !b_hs)      wr_cnt <= wr_cnt + CNT_W'(1);
      else if (!wr_gnt && b_hs) wr_cnt <= wr_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_gnt) begin
      rd_id_mem[rd_wptr]   <= per_id_i;
      rd_lane_mem[rd_wptr] <= lane;
    end
    if (wr_gnt) wr_id_mem[wr_wptr] <= per_id_i;
  end

  // ---- stage p1: peripheral response, one cycle after the AXI handshake ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_p1 <= 1'b0;
      rsp_opc_p1   <= 1'b0;
      rsp_id_p1    <= '0;
      rsp_rdata_p1 <= '0;
    end else begin
      rsp_valid_p1 <= r_hs | b_hs;
      if (r_hs) begin
        rsp_id_p1    <= rd_id_mem[rd_rptr];
        rsp_rdata_p1 <= axi_r_data_i[32*rd_lane_mem[rd_rptr] +: 32];
        rsp_opc_p1   <= axi_r_resp_i[1];
      end else if (b_hs) begin
        rsp_id_p1    <= wr_id_mem[wr_rptr];
        rsp_rdata_p1 <= '0;
        rsp_opc_p1   <= axi_b_resp_i[1];
      end
    end
  end

  assign per_r_valid_o = rsp_valid_p1;
  assign per_r_opc_o   = rsp_opc_p1;
  assign per_r_id_o    = rsp_id_p1;
  assign per_r_rdata_o = rsp_rdata_p1;

  assign busy_o = ar_valid_p0 | aw_valid_p0 | w_valid_p0 | (rd_cnt != '0) |
                  (wr_cnt != '0) | rsp_valid_p1;

  assign axi_ar_valid_o  = ar_valid_p0;
  assign axi_ar_addr_o   = ar_addr_p0;
  assign axi_ar_prot_o   = '0;
  assign axi_ar_region_o = '0;
  assign axi_ar_len_o    = '0;
  assign axi_ar_size_o   = 3'd2;
  assign axi_ar_burst_o  = 2'b01;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = '0;
  assign axi_ar_qos_o    = '0;
  assign axi_ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_ar_user_o   = '0;

  assign axi_aw_valid_o  = aw_valid_p0;
  assign axi_aw_addr_o   = aw_addr_p0;
  assign axi_aw_prot_o   = '0;
  assign axi_aw_region_o = '0;
  assign axi_aw_len_o    = '0;
  assign axi_aw_size_o   = 3'd2;
  assign axi_aw_burst_o  = 2'b01;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_cache_o  = '0;
  assign axi_aw_qos_o    = '0;
  assign axi_aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_aw_user_o   = '0;

  assign axi_w_valid_o = w_valid_p0;
  assign axi_w_data_o  = w_data_p0;
  assign axi_w_strb_o  = w_strb_p0;
  assign axi_w_user_o  = '0;
  assign axi_w_last_o  = 1'b1;

endmodule

// File: tb/tb_per2axi_mo.sv
// Directed and randomized bench for per2axi_mo with a queue-based transaction model.
module tb_per2axi_mo;
  localparam int N  = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, per_req, per_gnt, per_wen, per_r_valid, per_r_opc;
  logic [31:0] per_add, per_wdata, per_r_rdata;
  logic [3:0]  per_be;
  logic [4:0]  per_id, per_r_id;
  logic        aw_valid, aw_lock, aw_ready, ar_valid, ar_lock, ar_ready;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_prot, aw_size, ar_prot, ar_size;
  logic [3:0]  aw_region, aw_cache, aw_qos, aw_id, ar_region, ar_cache, ar_qos, ar_id;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [1:0]  aw_burst, ar_burst, r_resp, b_resp;
  logic [5:0]  aw_user, ar_user, w_user;
  logic        w_valid, w_last, w_ready, r_valid, r_ready, b_valid, b_ready, busy;
  logic [63:0] w_data, r_data;

  per2axi_mo dut (
    .clk_i(clk), .rst_i(rst), .per_req_i(per_req), .per_gnt_o(per_gnt),
    .per_add_i(per_add), .per_wen_i(per_wen), .per_wdata_i(per_wdata), .per_be_i(per_be),
    .per_id_i(per_id), .per_r_valid_o(per_r_valid), .per_r_opc_o(per_r_opc),
    .per_r_id_o(per_r_id), .per_r_rdata_o(per_r_rdata),
    .axi_aw_valid_o(aw_valid), .axi_aw_addr_o(aw_addr), .axi_aw_prot_o(aw_prot),
    .axi_aw_region_o(aw_region), .axi_aw_len_o(aw_len), .axi_aw_size_o(aw_size),
    .axi_aw_burst_o(aw_burst), .axi_aw_lock_o(aw_lock), .axi_aw_cache_o(aw_cache),
    .axi_aw_qos_o(aw_qos), .axi_aw_id_o(aw_id), .axi_aw_user_o(aw_user),
    .axi_aw_ready_i(aw_ready),
    .axi_ar_valid_o(ar_valid), .axi_ar_addr_o(ar_addr), .axi_ar_prot_o(ar_prot),
    .axi_ar_region_o(ar_region), .axi_ar_len_o(ar_len), .axi_ar_size_o(ar_size),
    .axi_ar_burst_o(ar_burst), .axi_ar_lock_o(ar_lock), .axi_ar_cache_o(ar_cache),
    .axi_ar_qos_o(ar_qos), .axi_ar_id_o(ar_id), .axi_ar_user_o(ar_user),
    .axi_ar_ready_i(ar_ready),
    .axi_w_valid_o(w_valid), .axi_w_data_o(w_data), .axi_w_strb_o(w_strb),
    .axi_w_user_o(w_user), .axi_w_last_o(w_last), .axi_w_ready_i(w_ready),
    .axi_r_valid_i(r_valid), .axi_r_data_i(r_data), .axi_r_resp_i(r_resp),
    .axi_r_ready_o(r_ready),
    .axi_b_valid_i(b_valid), .axi_b_resp_i(b_resp), .axi_b_ready_o(b_ready),
    .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  // Transaction model: what has been granted but not yet seen on each channel.
  logic [31:0] ar_q[$], aw_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  logic [4:0]  rd_id_q[$], wr_id_q[$];
  int          rd_lane_q[$];
  int          rd_issued, aw_cnt, w_cnt, b_cnt;
  bit          pend_v, pend_opc, last_gnt;
  logic [4:0]  pend_id;
  logic [31:0] pend_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit b_avail();
    int done;
    done = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
    return (done - b_cnt) > 0;
  endfunction

  task automatic model_clear();
    ar_q.delete(); aw_q.delete(); wd_q.delete(); ws_q.delete();
    rd_id_q.delete(); wr_id_q.delete(); rd_lane_q.delete();
    rd_issued = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; pend_v = 0;
  endtask

  task automatic idle();
    per_req = 0; per_wen = 0; per_add = 0; per_wdata = 0; per_be = 0; per_id = 0;
    r_valid = 0; r_data = 0; r_resp = 0; b_valid = 0; b_resp = 0;
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic cycle();
    bit eg, err, ebr, ebusy, arh, awh, wh, rh, bh, nv, nopc;
    logic [4:0]  nid;
    logic [31:0] ndata;
    logic [7:0]  s;
    int ln;
    #1;
    eg = per_req && (per_wen ? (ar_q.size() == 0 && rd_id_q.size() < N)
                             : (aw_q.size() == 0 && wd_q.size() == 0 && wr_id_q.size() < N));
    err = rd_id_q.size() != 0;
    ebr = wr_id_q.size() != 0 && !r_valid;
    ebusy = ar_q.size() != 0 || aw_q.size() != 0 || wd_q.size() != 0 ||
            rd_id_q.size() != 0 || wr_id_q.size() != 0 || pend_v;
    chk("gnt", per_gnt, eg);
    chk("r_ready", r_ready, err);
    chk("b_ready", b_ready, ebr);
    chk("busy", busy, ebusy);
    chk("ar_valid", ar_valid, ar_q.size() != 0);
    if (ar_q.size() != 0) chk("ar_addr", ar_addr, ar_q[0]);
    chk("aw_valid", aw_valid, aw_q.size() != 0);
    if (aw_q.size() != 0) chk("aw_addr", aw_addr, aw_q[0]);
    chk("w_valid", w_valid, wd_q.size() != 0);
    if (wd_q.size() != 0) begin
      chk("w_data", w_data, wd_q[0]);
      chk("w_strb", w_strb, ws_q[0]);
    end
    chk("rsp_valid", per_r_valid, pend_v);
    if (pend_v) begin
      chk("rsp_id", per_r_id, pend_id);
      chk("rsp_rdata", per_r_rdata, pend_data);
      chk("rsp_opc", per_r_opc, pend_opc);
    end
    last_gnt = eg;
    arh = ar_q.size() != 0 && ar_ready;
    awh = aw_q.size() != 0 && aw_ready;
    wh  = wd_q.size() != 0 && w_ready;
    rh  = r_valid && err;
    bh  = b_valid && ebr;
    nv = 0; nopc = 0; nid = 0; ndata = 0;
    if (rh) begin
      ln = rd_lane_q.pop_front();
      nid = rd_id_q.pop_front();
      ndata = 32'(r_data >> (32 * ln));
      nopc = r_resp[1];
      nv = 1;
      rd_issued--;
    end else if (bh) begin
      nid = wr_id_q.pop_front();
      nopc = b_resp[1];
      nv = 1;
      b_cnt++;
    end
    if (arh) begin void'(ar_q.pop_front()); rd_issued++; end
    if (awh) begin void'(aw_q.pop_front()); aw_cnt++; end
    if (wh)  begin void'(wd_q.pop_front()); void'(ws_q.pop_front()); w_cnt++; end
    if (eg) begin
      ln = (per_add / 4) % (DW / 32);
      if (per_wen) begin
        ar_q.push_back(per_add); rd_id_q.push_back(per_id); rd_lane_q.push_back(ln);
      end else begin
        s = 8'(per_be) << (4 * ln);
        aw_q.push_back(per_add); wd_q.push_back({per_wdata, per_wdata});
        ws_q.push_back(s); wr_id_q.push_back(per_id);
      end
    end
    @(posedge clk);
    if (rst) model_clear();
    else begin
      pend_v = nv; pend_id = nid; pend_data = ndata; pend_opc = nopc;
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    idle(); ar_ready = 1; aw_ready = 1; w_ready = 1;
    while ((ar_q.size() || aw_q.size() || wd_q.size() || rd_id_q.size() ||
            wr_id_q.size() || pend_v) && n < 200) begin
      r_valid = rd_issued > 0; r_data = {$urandom, $urandom}; r_resp = 2'($urandom);
      b_valid = b_avail(); b_resp = 2'($urandom);
      cycle();
      n++;
    end
    idle();
    chk("drain_in_budget", n < 200, 1);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    int k;
    model_clear();
    idle(); ar_ready = 0; aw_ready = 0; w_ready = 0;
    rst = 1;
    cycle(); cycle();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_rsp_valid", per_r_valid, 0);
    chk("rst_rdata", per_r_rdata, 0);
    chk("rst_opc", per_r_opc, 0);
    cycle();

    // Test 1: read on upper lane
    per_req = 1; per_wen = 1; per_add = 32'h1000_0004; per_id = 5'd3;
    cycle();
    idle();
    chk("t1_ar_valid", ar_valid, 1);
    chk("t1_ar_addr", ar_addr, 32'h1000_0004);
    chk("t1_ar_size", ar_size, 2);
    chk("t1_ar_len", ar_len, 0);
    chk("t1_ar_burst", ar_burst, 1);
    ar_ready = 1;
    cycle();
    r_valid = 1; r_data = 64'hAAAA_BBBB_CCCC_DDDD; r_resp = 2'b00;
    cycle();
    idle();
    chk("t1_rsp_valid", per_r_valid, 1);
    chk("t1_rdata", per_r_rdata, 32'hAAAA_BBBB);
    chk("t1_id", per_r_id, 3);
    chk("t1_opc", per_r_opc, 0);
    cycle();
    chk("t1_rsp_pulse", per_r_valid, 0);

    // Test 2: write on lane 0 with SLVERR response
    per_req = 1; per_wen = 0; per_add = 32'h8; per_be = 4'hF; per_wdata = 32'h1234_5678;
    per_id = 5'd7; aw_ready = 1; w_ready = 1;
    cycle();
    idle();
    chk("t2_w_strb", w_strb, 8'h0F);
    chk("t2_w_data", w_data, 64'h1234_5678_1234_5678);
    chk("t2_w_last", w_last, 1);
    cycle();
    b_valid = 1; b_resp = 2'b10;
    cycle();
    idle();
    chk("t2_rsp_valid", per_r_valid, 1);
    chk("t2_opc", per_r_opc, 1);
    chk("t2_rdata", per_r_rdata, 0);
    chk("t2_id", per_r_id, 7);
    cycle();

    // Test 3: read FIFO fills at four, writes still granted
    k = 0; ar_ready = 1;
    for (int c = 0; c < 12; c++) begin
      per_req = 1; per_wen = 1; per_add = $urandom; per_id = 5'(10 + k);
      cycle();
      if (last_gnt) k++;
    end
    chk("t3_grants", k, 4);
    #1 chk("t3_fifth_blocked", per_gnt, 0);
    per_wen = 0; per_add = $urandom; per_wdata = $urandom; per_be = 4'hF; per_id = 5'd20;
    #1 chk("t3_write_granted", per_gnt, 1);
    cycle();
    per_wen = 1; per_add = 32'h44; per_id = 5'd14; aw_ready = 1; w_ready = 1;
    cycle(); cycle();
    #1 chk("t3_still_blocked", per_gnt, 0);
    r_valid = 1; r_data = {$urandom, $urandom}; r_resp = 0;
    cycle();
    r_valid = 0;
    #1 chk("t3_fifth_granted", per_gnt, 1);
    cycle();
    drain();

    // Test 4: simultaneous R and B
    per_req = 1; per_wen = 1; per_add = 32'h0; per_id = 5'd9;
    cycle();
    per_wen = 0; per_add = 32'h4; per_wdata = 32'hCAFE_0001; per_be = 4'hF; per_id = 5'd10;
    cycle();
    idle();
    cycle();
    r_valid = 1; r_data = 64'h1111_2222_3333_4444; r_resp = 0; b_valid = 1; b_resp = 0;
    #1 chk("t4_b_ready_stall", b_ready, 0);
    chk("t4_r_ready", r_ready, 1);
    cycle();
    r_valid = 0;
    #1 chk("t4_b_ready_next", b_ready, 1);
    chk("t4_first_id", per_r_id, 9);
    chk("t4_first_rdata", per_r_rdata, 32'h3333_4444);
    cycle();
    b_valid = 0;
    chk("t4_second_valid", per_r_valid, 1);
    chk("t4_second_id", per_r_id, 10);
    chk("t4_second_rdata", per_r_rdata, 0);
    cycle();

    // Test 5: AW stalled, W completes first, next write held
    aw_ready = 0; w_ready = 1;
    per_req = 1; per_wen = 0; per_add = 32'h14; per_wdata = 32'hDEAD_BEEF; per_be = 4'h3;
    per_id = 5'd21;
    cycle();
    chk("t5_w_strb", w_strb, 8'h30);
    per_add = 32'h20; per_id = 5'd22;
    for (int c = 0; c < 5; c++) begin
      #1 chk("t5_aw_hold", aw_valid, 1);
      chk("t5_aw_addr", aw_addr, 32'h14);
      chk("t5_next_blocked", per_gnt, 0);
      cycle();
      chk("t5_w_done", w_valid, 0);
    end
    aw_ready = 1;
    cycle();
    #1 chk("t5_next_granted", per_gnt, 1);
    cycle();
    drain();

    // Test 6: reset with two reads in flight, then a fresh read
    ar_ready = 1;
    per_req = 1; per_wen = 1; per_add = 32'h100; per_id = 5'd1;
    cycle();
    idle(); cycle();
    per_req = 1; per_wen = 1; per_add = 32'h104; per_id = 5'd2;
    cycle();
    idle(); cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_busy", busy, 0);
    chk("t6_ar_valid", ar_valid, 0);
    chk("t6_r_ready", r_ready, 0);
    chk("t6_b_ready", b_ready, 0);
    per_req = 1; per_wen = 1; per_add = 32'h1000_0004; per_id = 5'd3;
    cycle();
    idle();
    chk("t6_ar_addr", ar_addr, 32'h1000_0004);
    cycle();
    r_valid = 1; r_data = 64'hAAAA_BBBB_CCCC_DDDD; r_resp = 0;
    cycle();
    idle();
    chk("t6_rdata", per_r_rdata, 32'hAAAA_BBBB);
    chk("t6_id", per_r_id, 3);
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      per_req = $urandom_range(0, 1); per_wen = $urandom_range(0, 1);
      per_add = $urandom; per_wdata = $urandom; per_be = 4'($urandom); per_id = 5'($urandom);
      ar_ready = ($urandom % 4) != 0; aw_ready = ($urandom % 4) != 0;
      w_ready = ($urandom % 4) != 0;
      r_valid = rd_issued > 0 && ($urandom % 3) != 0;
      r_data = {$urandom, $urandom}; r_resp = 2'($urandom);
      b_valid = b_avail() && ($urandom % 3) != 0; b_resp = 2'($urandom);
      cycle();
    end
    drain();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
